// File: rtl/wiring_driver_pkg.sv
// Shared types and constants for the wiring_driver sequencer.
// Holds the FSM state encoding and the width of the settle-time counter.
package wiring_driver_pkg;

    localparam int CYCLE_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        PULSE  = 3'd2,
        SETTLE = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [CYCLE_W-1:0] CYCLE_MAX = {CYCLE_W{1'b1}};

    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] value);
        return (value == CYCLE_MAX) ? value : value + CYCLE_W'(1);
    endfunction

endpackage

// File: rtl/wiring_driver_sat_counter.sv
// Up-counter that clears on request and sticks at all-ones instead of wrapping.
// Used to report the settle time of one wiring-block run.
module wiring_driver_sat_counter
    import wiring_driver_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [CYCLE_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/wiring_driver.sv
// Sequencer that clears, pulses and waits on a wiring block, then reports its output.
// Optional macro WIRING_DRIVER_OUT_ACCUM_EN ORs dut_out over the whole run into rsp_out.
//
// state  | meaning
// IDLE   | ready for a command, all drive outputs low
// CLEAR  | one-cycle dut_logic_reset pulse
// PULSE  | one-cycle dut_in drive with the latched command, counter cleared
// SETTLE | fixed settle delay, dut_running ignored
// WAIT   | wait for dut_running low or timeout, then capture
// RESP   | hold response until rsp_ready
module wiring_driver
    import wiring_driver_pkg::*;
#(
    parameter int INPUT_WIDTH    = 2,
    parameter int OUTPUT_WIDTH   = 1,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [INPUT_WIDTH-1:0]  cmd_in,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUTPUT_WIDTH-1:0] rsp_out,
    output logic                    rsp_timeout,
    output logic [CYCLE_W-1:0]      rsp_cycles,
    output logic                    dut_logic_reset,
    output logic [INPUT_WIDTH-1:0]  dut_in,
    input  logic                    dut_running,
    input  logic [OUTPUT_WIDTH-1:0] dut_out
);

    // The phase timer counts down to zero; loads are terminal count minus one.
    localparam logic [CYCLE_W-1:0] SETTLE_LOAD  = CYCLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] TIMEOUT_LOAD = CYCLE_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [INPUT_WIDTH-1:0]  cmd_q;
    logic [CYCLE_W-1:0]      tmr_q;
    logic [CYCLE_W-1:0]      tmr_nxt;
    logic [OUTPUT_WIDTH-1:0] out_q;
    logic [OUTPUT_WIDTH-1:0] out_nxt;
    logic                    timeout_q;
    logic                    timeout_nxt;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic [CYCLE_W-1:0]      cycle_cnt;
    logic [OUTPUT_WIDTH-1:0] out_sample;

    wiring_driver_sat_counter u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_cnt)
    );

`ifdef WIRING_DRIVER_OUT_ACCUM_EN
    logic [OUTPUT_WIDTH-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (state == PULSE) begin
            acc_q <= '0;
        end else if ((state == SETTLE) || (state == WAIT)) begin
            acc_q <= acc_q | dut_out;
        end
    end

    assign out_sample = acc_q | dut_out;
`else
    assign out_sample = dut_out;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            tmr_q     <= '0;
            out_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tmr_q     <= tmr_nxt;
            out_q     <= out_nxt;
            timeout_q <= timeout_nxt;
            if ((state == IDLE) && cmd_valid) begin
                cmd_q <= cmd_in;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        tmr_nxt         = tmr_q;
        out_nxt         = out_q;
        timeout_nxt     = timeout_q;
        cnt_clear       = 1'b0;
        cnt_en          = 1'b0;
        cmd_ready       = 1'b0;
        dut_logic_reset = 1'b0;
        dut_in          = '0;
        rsp_valid       = 1'b0;
        rsp_out         = '0;
        rsp_timeout     = 1'b0;
        rsp_cycles      = '0;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                dut_logic_reset = 1'b1;
                state_nxt       = PULSE;
            end
            PULSE: begin
                dut_in    = cmd_q;
                cnt_clear = 1'b1;
                tmr_nxt   = SETTLE_LOAD;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                cnt_en = 1'b1;
                if (tmr_q == '0) begin
                    tmr_nxt   = TIMEOUT_LOAD;
                    state_nxt = WAIT;
                end else begin
                    tmr_nxt = tmr_q - CYCLE_W'(1);
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                // A block that stops on the last allowed cycle is not a timeout.
                if (!dut_running || (tmr_q == '0)) begin
                    out_nxt     = out_sample;
                    timeout_nxt = dut_running;
                    state_nxt   = RESP;
                end else begin
                    tmr_nxt = tmr_q - CYCLE_W'(1);
                end
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_out     = out_q;
                rsp_timeout = timeout_q;
                rsp_cycles  = cycle_cnt;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/wiring_driver.md
WIRING_DRIVER -- requirements
Module: wiring_driver

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 2, width of the stimulus vector driven into the wiring block.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 1, width of the wiring block output vector captured.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, range 1..255: cycles after the input pulse before dut_running is sampled.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, range 1..65535: maximum WAIT cycles before a forced capture.
REQ-005 SHALL have ports: clk in 1, the single clock; reset in 1, synchronous, active-low.
REQ-006 SHALL have ports: cmd_valid in 1; cmd_ready out 1; cmd_in in INPUT_WIDTH, the stimulus to apply.
REQ-007 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_out out OUTPUT_WIDTH; rsp_timeout out 1; rsp_cycles out 16, the settle time.
REQ-008 SHALL have ports: dut_logic_reset out 1; dut_in out INPUT_WIDTH; dut_running in 1; dut_out in OUTPUT_WIDTH, connected to the wiring block.

Function
REQ-009 SHALL implement FSM states IDLE, CLEAR, PULSE, SETTLE, WAIT, RESP.
REQ-010 IDLE: cmd_ready=1; on cmd_valid latch cmd_in, go to CLEAR; all other outputs 0.
REQ-011 CLEAR: dut_logic_reset=1 for exactly one cycle, then go to PULSE.
REQ-012 PULSE: dut_in=latched command for exactly one cycle (0 in every other state), then go to SETTLE; cycle counter cleared to 0.
REQ-013 SETTLE: counter +1 per cycle; dut_running ignored; after SETTLE_CYCLES cycles go to WAIT.
REQ-014 WAIT: counter +1 per cycle; if dut_running==0 in that cycle, capture dut_out and go to RESP with rsp_timeout=0.
REQ-015 WAIT: when the WAIT-cycle count reaches TIMEOUT_CYCLES with dut_running still 1, capture dut_out, set rsp_timeout=1, go to RESP.
REQ-016 rsp_cycles = counter value including the capture cycle, 16-bit, saturating at 16'hFFFF (no wrap).
REQ-017 RESP: rsp_valid=1; rsp_out, rsp_timeout, rsp_cycles stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE.
REQ-018 cmd_ready=0 outside IDLE; cmd_valid outside IDLE SHALL be ignored, with no latch and no queuing.
REQ-019 Back-to-back: minimum one IDLE cycle between a response handshake and the next command accept.
REQ-020 An all-zero cmd_in SHALL run the full sequence unchanged.

Reset
REQ-021 reset==0 at a clk edge SHALL force IDLE from any state, including mid-PULSE/WAIT/RESP.
REQ-022 After reset: cmd_ready=1; rsp_valid, rsp_out, rsp_timeout, rsp_cycles, dut_logic_reset, dut_in all 0; counter 0.
REQ-023 An interrupted command SHALL produce no response.

Configuration
REQ-024 Macro WIRING_DRIVER_OUT_ACCUM_EN defined: rsp_out = bitwise OR of dut_out sampled every cycle from SETTLE entry through the capture cycle, catching single-cycle output pulses.
REQ-025 Macro WIRING_DRIVER_OUT_ACCUM_EN undefined: rsp_out = dut_out sampled in the capture cycle only; no accumulator register.

Structure
REQ-026 Package wiring_driver_pkg SHALL hold the state enum and the constant CYCLE_W=16.
REQ-027 Sub-module wiring_driver_sat_counter (clear, enable, saturating CYCLE_W-bit count) SHALL implement the cycle counter.

Verification
REQ-028 Reset held low 3 cycles, then high -> cmd_ready=1, every other output 0.
REQ-029 Defaults, cmd_in=2'b01, model drops running on the 5th WAIT cycle with dut_out=1 -> dut_logic_reset one cycle, then dut_in=2'b01 one cycle; response rsp_out=1, rsp_timeout=0, rsp_cycles=7.
REQ-030 TIMEOUT_CYCLES=8, model holds dut_running=1 -> rsp_timeout=1, rsp_cycles=10.
REQ-031 rsp_ready held low 4 cycles in RESP, cmd_valid pulsed meanwhile -> response fields stable, command ignored, cmd_ready=0 throughout.
REQ-032 Reset asserted during WAIT -> next cycle IDLE, no rsp_valid, dut_in=0.
REQ-033 With WIRING_DRIVER_OUT_ACCUM_EN, dut_out pulses 1 for one SETTLE cycle and is 0 at capture -> rsp_out=1; without the macro -> rsp_out=0.
